vend_credit_controller: RTL and testbench

- Sequences one vending transaction: accumulates coin credit, requests product dispense once credit reaches PRICE, then returns change through a coin-out dispenser.
- Sits between the coin-acceptor pulses (nickel/dime/quarter) and the product and change dispensers.
- Owns the credit register and the dispense/change handshakes.
- Its valid pulse marks a completed vend.

---
 rtl/vend_pkg.sv | 21 ++
 rtl/vend_credit_controller_if.sv | 34 +++
 rtl/vend_change_issuer.sv | 62 ++++++
 rtl/vend_credit_controller.sv | 126 ++++++++++++
 tb/tb_vend_credit_controller.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/vend_pkg.sv
// vend_pkg: shared types and constants for the vending credit controller.
//   state_t  : transaction state (IDLE, ACCEPT, VEND, CHANGE)
//   *_C      : coin values in cents
//   credit_t : credit value at the default credit width
package vend_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCEPT = 2'd1,
      VEND   = 2'd2,
      CHANGE = 2'd3
   } state_t;

   localparam int NICKEL_C  = 5;
   localparam int DIME_C    = 10;
   localparam int QUARTER_C = 25;

   localparam int CREDIT_W_DEF = 7;
   typedef logic [CREDIT_W_DEF-1:0] credit_t;

endpackage

// File: rtl/vend_credit_controller_if.sv
// vend_credit_controller_if: coin-acceptor, dispenser and status signals of
// the vending credit controller.
//   slave  : controller side (coins/cancel/readies in, requests/status out)
//   master : environment side (drives coins/cancel/readies)
interface vend_credit_controller_if #(
   parameter int CREDIT_W = 7
) ();
   logic                nickel;
   logic                dime;
   logic                quarter;
   logic                cancel;
   logic                vend_ready;
   logic                chg_ready;
   logic                vend_req;
   logic                chg_nickel;
   logic                chg_dime;
   logic                chg_quarter;
   logic                coin_reject;
   logic                valid;
   logic [CREDIT_W-1:0] credit;
   logic                busy;

   modport slave (
      input  nickel, dime, quarter, cancel, vend_ready, chg_ready,
      output vend_req, chg_nickel, chg_dime, chg_quarter, coin_reject,
             valid, credit, busy
   );

   modport master (
      output nickel, dime, quarter, cancel, vend_ready, chg_ready,
      input  vend_req, chg_nickel, chg_dime, chg_quarter, coin_reject,
             valid, credit, busy
   );
endinterface

// File: rtl/vend_change_issuer.sv
// vend_change_issuer: pays out an amount as coins, greedy largest-first.
//   clk, reset_n : clock, asynchronous active-low reset
//   start/amount : load a non-zero amount to pay out
//   chg_ready    : dispenser accepts the current coin at this edge
//   chg_*        : one-hot coin request, stable until chg_ready
//   done         : last coin is being accepted at this edge
//   remaining    : amount still to be paid
module vend_change_issuer
   import vend_pkg::*;
#(
   parameter int CREDIT_W = 7
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
   input  logic [CREDIT_W-1:0] amount,
   input  logic                chg_ready,
   output logic                chg_nickel,
   output logic                chg_dime,
   output logic                chg_quarter,
   output logic                done,
   output logic [CREDIT_W-1:0] remaining
);
   localparam logic [CREDIT_W-1:0] NICKEL_V  = CREDIT_W'(NICKEL_C);
   localparam logic [CREDIT_W-1:0] DIME_V    = CREDIT_W'(DIME_C);
   localparam logic [CREDIT_W-1:0] QUARTER_V = CREDIT_W'(QUARTER_C);

   logic                active_reg;
   logic [CREDIT_W-1:0] remaining_reg;
   logic                sel_q, sel_d, sel_n;
   logic [CREDIT_W-1:0] coin_val;

   // Selection is decoded from the remaining amount register, so the request
   // only moves at a handshake edge.
   always_comb begin
      sel_q    = remaining_reg >= QUARTER_V;
      sel_d    = !sel_q && (remaining_reg >= DIME_V);
      sel_n    = !sel_q && !sel_d;
      coin_val = sel_q ? QUARTER_V : (sel_d ? DIME_V : NICKEL_V);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         active_reg    <= 1'b0;
         remaining_reg <= '0;
      end else if (start) begin
         active_reg    <= 1'b1;
         remaining_reg <= amount;
      end else if (active_reg && chg_ready) begin
         remaining_reg <= remaining_reg - coin_val;
         if (remaining_reg == coin_val)
            active_reg <= 1'b0;
      end
   end

   assign chg_quarter = active_reg && sel_q;
   assign chg_dime    = active_reg && sel_d;
   assign chg_nickel  = active_reg && sel_n;
   assign done        = active_reg && chg_ready && (remaining_reg == coin_val);
   assign remaining   = remaining_reg;

endmodule

// File: rtl/vend_credit_controller.sv
// vend_credit_controller: one vending transaction - accumulates coin credit,
// requests a product once credit reaches PRICE, then returns change.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : coin pulses, cancel, dispenser handshakes, status outputs
module vend_credit_controller
   import vend_pkg::*;
#(
   parameter int PRICE    = 25,
   parameter int CREDIT_W = 7
) (
   input  logic                      clk,
   input  logic                      reset_n,
   vend_credit_controller_if.slave   bus
);
   localparam logic [CREDIT_W-1:0] PRICE_V   = CREDIT_W'(PRICE);
   localparam logic [CREDIT_W-1:0] NICKEL_V  = CREDIT_W'(NICKEL_C);
   localparam logic [CREDIT_W-1:0] DIME_V    = CREDIT_W'(DIME_C);
   localparam logic [CREDIT_W-1:0] QUARTER_V = CREDIT_W'(QUARTER_C);

   state_t              state_reg, state_next;
   logic [CREDIT_W-1:0] credit_reg, credit_next;
   logic                valid_reg, valid_next;
   logic                reject_reg, reject_next;

   logic                start;
   logic [CREDIT_W-1:0] start_amount;
   logic                issue_done;
   logic [CREDIT_W-1:0] remaining;

   logic [1:0]          coin_cnt;
   logic [CREDIT_W-1:0] coin_val;
   logic [CREDIT_W-1:0] sum;
   logic [CREDIT_W-1:0] rem;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg  <= IDLE;
         credit_reg <= '0;
         valid_reg  <= 1'b0;
         reject_reg <= 1'b0;
      end else begin
         state_reg  <= state_next;
         credit_reg <= credit_next;
         valid_reg  <= valid_next;
         reject_reg <= reject_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      credit_next  = credit_reg;
      valid_next   = 1'b0;
      reject_next  = 1'b0;
      start        = 1'b0;
      start_amount = '0;
      coin_cnt     = {1'b0, bus.nickel} + {1'b0, bus.dime} + {1'b0, bus.quarter};
      coin_val     = bus.quarter ? QUARTER_V : (bus.dime ? DIME_V : NICKEL_V);
      sum          = credit_reg + coin_val;
      rem          = credit_reg - PRICE_V;

      // A coin is refused when ambiguous (several pulses), when the
      // transaction is committed, or when it collides with cancel.
      if (coin_cnt != 2'd0)
         reject_next = (coin_cnt > 2'd1) || bus.cancel ||
                       (state_reg == VEND) || (state_reg == CHANGE);

      case (state_reg)
         IDLE, ACCEPT: begin
            if (bus.cancel) begin
               // Credit moves into the change issuer as a refund.
               if (state_reg == ACCEPT) begin
                  start        = 1'b1;
                  start_amount = credit_reg;
                  credit_next  = '0;
                  state_next   = CHANGE;
               end
            end else if (coin_cnt == 2'd1) begin
               credit_next = sum;
               state_next  = (sum >= PRICE_V) ? VEND : ACCEPT;
            end
         end
         VEND: begin
            if (bus.vend_ready) begin
               valid_next  = 1'b1;
               credit_next = '0;
               if (rem != '0) begin
                  start        = 1'b1;
                  start_amount = rem;
                  state_next   = CHANGE;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         CHANGE: begin
            if (issue_done)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   vend_change_issuer #(
      .CREDIT_W (CREDIT_W)
   ) u_issuer (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .amount      (start_amount),
      .chg_ready   (bus.chg_ready),
      .chg_nickel  (bus.chg_nickel),
      .chg_dime    (bus.chg_dime),
      .chg_quarter (bus.chg_quarter),
      .done        (issue_done),
      .remaining   (remaining)
   );

   // While paying change the issuer owns the outstanding amount; credit_reg
   // is zero then, so the mux just picks whichever register holds the value.
   assign bus.credit      = (state_reg == CHANGE) ? remaining : credit_reg;
   assign bus.vend_req    = (state_reg == VEND);
   assign bus.busy        = (state_reg == VEND) || (state_reg == CHANGE);
   assign bus.valid       = valid_reg;
   assign bus.coin_reject = reject_reg;

endmodule

// File: tb/tb_vend_credit_controller.sv
// tb_vend_credit_controller: directed bench for vend_credit_controller with
// one instance at PRICE=25 (a) and one at PRICE=50 (b).
module tb_vend_credit_controller;
   logic clk;
   logic reset_n;
   int   tests;
   int   fails;

   vend_credit_controller_if #(.CREDIT_W(7)) a_if ();
   vend_credit_controller_if #(.CREDIT_W(7)) b_if ();

   vend_credit_controller #(.PRICE(25), .CREDIT_W(7)) u_a (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (a_if)
   );

   vend_credit_controller #(.PRICE(50), .CREDIT_W(7)) u_b (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (b_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
      $display("[TB] check %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   initial begin
      tests = 0;
      fails = 0;
      {a_if.nickel, a_if.dime, a_if.quarter, a_if.cancel, a_if.vend_ready, a_if.chg_ready} = '0;
      {b_if.nickel, b_if.dime, b_if.quarter, b_if.cancel, b_if.vend_ready, b_if.chg_ready} = '0;
      reset_n = 1'b0;
      tick();
      tick();
      chk("rst_credit", 32'(a_if.credit), 0);
      chk("rst_busy", 32'(a_if.busy), 0);
      chk("rst_vend_req", 32'(a_if.vend_req), 0);
      chk("rst_valid", 32'(a_if.valid), 0);
      reset_n = 1'b1;
      tick();

      // 1: exact price, delayed vend_ready
      a_if.quarter = 1; tick(); a_if.quarter = 0;
      chk("t1_credit", 32'(a_if.credit), 25);
      chk("t1_vend_req", 32'(a_if.vend_req), 1);
      tick();
      chk("t1_hold1", 32'(a_if.vend_req), 1);
      tick();
      chk("t1_hold2", 32'(a_if.vend_req), 1);
      a_if.vend_ready = 1; tick(); a_if.vend_ready = 0;
      chk("t1_valid", 32'(a_if.valid), 1);
      chk("t1_credit0", 32'(a_if.credit), 0);
      chk("t1_busy", 32'(a_if.busy), 0);
      chk("t1_chg", 32'({a_if.chg_nickel, a_if.chg_dime, a_if.chg_quarter}), 0);
      tick();
      chk("t1_valid_once", 32'(a_if.valid), 0);

      // 2: three dimes, nickel change
      a_if.dime = 1; tick();
      chk("t2_c10", 32'(a_if.credit), 10);
      chk("t2_busy10", 32'(a_if.busy), 0);
      tick();
      chk("t2_c20", 32'(a_if.credit), 20);
      tick(); a_if.dime = 0;
      chk("t2_c30", 32'(a_if.credit), 30);
      chk("t2_vend_req", 32'(a_if.vend_req), 1);
      a_if.vend_ready = 1; tick(); a_if.vend_ready = 0;
      chk("t2_valid", 32'(a_if.valid), 1);
      chk("t2_c5", 32'(a_if.credit), 5);
      chk("t2_chg_n", 32'({a_if.chg_nickel, a_if.chg_dime, a_if.chg_quarter}), 3'b100);
      tick();
      chk("t2_chg_n_hold", 32'({a_if.chg_nickel, a_if.chg_dime, a_if.chg_quarter}), 3'b100);
      chk("t2_valid_once", 32'(a_if.valid), 0);
      a_if.chg_ready = 1; tick(); a_if.chg_ready = 0;
      chk("t2_c0", 32'(a_if.credit), 0);
      chk("t2_busy0", 32'(a_if.busy), 0);
      chk("t2_chg_off", 32'({a_if.chg_nickel, a_if.chg_dime, a_if.chg_quarter}), 0);

      // 3: nickel, dime, cancel -> refund dime then nickel, no valid
      a_if.nickel = 1; tick(); a_if.nickel = 0;
      chk("t3_c5", 32'(a_if.credit), 5);
      a_if.dime = 1; tick(); a_if.dime = 0;
      chk("t3_c15", 32'(a_if.credit), 15);
      a_if.cancel = 1; tick(); a_if.cancel = 0;
      chk("t3_ref15", 32'(a_if.credit), 15);
      chk("t3_chg_d", 32'({a_if.chg_nickel, a_if.chg_dime, a_if.chg_quarter}), 3'b010);
      chk("t3_no_valid", 32'(a_if.valid), 0);
      a_if.chg_ready = 1; tick();
      chk("t3_c5b", 32'(a_if.credit), 5);
      chk("t3_chg_n", 32'({a_if.chg_nickel, a_if.chg_dime, a_if.chg_quarter}), 3'b100);
      tick(); a_if.chg_ready = 0;
      chk("t3_c0", 32'(a_if.credit), 0);
      chk("t3_busy0", 32'(a_if.busy), 0);
      chk("t3_no_valid2", 32'(a_if.valid), 0);

      // cancel in IDLE is ignored
      a_if.cancel = 1; tick(); a_if.cancel = 0;
      chk("idle_cancel_busy", 32'(a_if.busy), 0);

      // 4: rejections
      a_if.nickel = 1; a_if.dime = 1; tick(); a_if.nickel = 0; a_if.dime = 0;
      chk("t4_reject", 32'(a_if.coin_reject), 1);
      chk("t4_c0", 32'(a_if.credit), 0);
      tick();
      chk("t4_reject_once", 32'(a_if.coin_reject), 0);
      a_if.quarter = 1; tick();
      chk("t4_c25", 32'(a_if.credit), 25);
      chk("t4_no_reject", 32'(a_if.coin_reject), 0);
      tick(); a_if.quarter = 0;
      chk("t4_vend_reject", 32'(a_if.coin_reject), 1);
      chk("t4_c25_kept", 32'(a_if.credit), 25);
      chk("t4_vend_req", 32'(a_if.vend_req), 1);
      a_if.vend_ready = 1; tick(); a_if.vend_ready = 0;
      chk("t4_valid", 32'(a_if.valid), 1);
      chk("t4_c0b", 32'(a_if.credit), 0);

      // 5: PRICE=50, 65 credit, change 15 with stalled dispenser
      b_if.dime = 1;
      tick(); chk("t5_c10", 32'(b_if.credit), 10);
      tick(); chk("t5_c20", 32'(b_if.credit), 20);
      tick(); chk("t5_c30", 32'(b_if.credit), 30);
      tick(); b_if.dime = 0;
      chk("t5_c40", 32'(b_if.credit), 40);
      chk("t5_no_vend", 32'(b_if.vend_req), 0);
      b_if.quarter = 1; tick(); b_if.quarter = 0;
      chk("t5_c65", 32'(b_if.credit), 65);
      chk("t5_vend_req", 32'(b_if.vend_req), 1);
      b_if.vend_ready = 1; tick(); b_if.vend_ready = 0;
      chk("t5_valid", 32'(b_if.valid), 1);
      chk("t5_c15", 32'(b_if.credit), 15);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("t5_chg_d_stall%0d", i),
             32'({b_if.chg_nickel, b_if.chg_dime, b_if.chg_quarter}), 3'b010);
         tick();
      end
      b_if.chg_ready = 1; tick();
      chk("t5_c5", 32'(b_if.credit), 5);
      chk("t5_chg_n", 32'({b_if.chg_nickel, b_if.chg_dime, b_if.chg_quarter}), 3'b100);
      tick(); b_if.chg_ready = 0;
      chk("t5_c0", 32'(b_if.credit), 0);
      chk("t5_busy0", 32'(b_if.busy), 0);

      // 6: asynchronous reset during a quarter refund
      b_if.quarter = 1; tick(); b_if.quarter = 0;
      chk("t6_c25", 32'(b_if.credit), 25);
      b_if.cancel = 1; tick(); b_if.cancel = 0;
      chk("t6_chg_q", 32'({b_if.chg_nickel, b_if.chg_dime, b_if.chg_quarter}), 3'b001);
      #2;
      reset_n = 1'b0;
      #1;
      chk("t6_rst_chg", 32'({b_if.chg_nickel, b_if.chg_dime, b_if.chg_quarter}), 0);
      chk("t6_rst_credit", 32'(b_if.credit), 0);
      chk("t6_rst_busy", 32'(b_if.busy), 0);
      chk("t6_rst_misc", 32'({b_if.vend_req, b_if.valid, b_if.coin_reject}), 0);
      tick();
      #2;
      reset_n = 1'b1;
      tick();
      chk("t6_idle_credit", 32'(b_if.credit), 0);
      chk("t6_idle_busy", 32'(b_if.busy), 0);
      b_if.nickel = 1; tick(); b_if.nickel = 0;
      chk("t6_nickel", 32'(b_if.credit), 5);
      chk("t6_no_reject", 32'(b_if.coin_reject), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
